// File: rtl/seg_pipe_elastic.sv
// Elastic DEPTH-stage payload pipeline with valid/ready handshakes,
// partial flush of younger stages, and collapse or lockstep advance.
module seg_pipe_elastic #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 5,
    parameter bit COLLAPSE = 1'b1,
    localparam int SW      = $clog2(DEPTH),
    localparam int OW      = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             flush_i,
    input  logic [SW-1:0]    flush_stage_i,
    output logic [DEPTH-1:0] stage_valid_o,
    output logic [OW-1:0]    occ_o
);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data    [DEPTH];
    logic [WIDTH-1:0] srcData [DEPTH];
    logic [DEPTH-1:0] squash;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] srcValid;
    logic [DEPTH:0]   rdy;
    logic [SW-1:0]    flushStage;
    logic             adv;
    logic             inXfer;

    always_comb begin
        flushStage = (flush_stage_i > SW'(DEPTH - 1)) ? SW'(DEPTH - 1)
                                                      : flush_stage_i;
        for (int k = 0; k < DEPTH; k++) begin
            squash[k] = flush_i && (SW'(k) <= flushStage);
        end
    end

    // Ready ripples from the exit back to the entry through empty stages.
    always_comb begin
        rdy[DEPTH] = out_ready_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~valid[k] | rdy[k+1];
        end
    end

    assign adv         = out_ready_i | ~valid[DEPTH-1];
    assign in_ready_o  = (COLLAPSE ? rdy[0] : adv) & ~flush_i;
    assign inXfer      = in_valid_i & in_ready_o;
    assign out_valid_o = valid[DEPTH-1] & ~squash[DEPTH-1];

    // A squashed stage never feeds the stage above it.
    always_comb begin
        srcValid[0] = inXfer;
        srcData[0]  = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            srcValid[k] = valid[k-1] & ~squash[k-1];
            srcData[k]  = data[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            load[k] = COLLAPSE ? rdy[k] : adv;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (squash[k]) begin
                    valid[k] <= 1'b0;
                end else if (load[k]) begin
                    valid[k] <= srcValid[k];
                    if (srcValid[k]) begin
                        data[k] <= srcData[k];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_o = occ_o + OW'(valid[k]);
        end
    end

    assign out_data_o    = data[DEPTH-1];
    assign stage_valid_o = valid;

endmodule

// File: tb/tb_seg_pipe_elastic.sv
// Randomised scoreboard bench for seg_pipe_elastic, driving a collapsing
// and a lockstep instance with shared stimulus against an item-level model.
module tb_seg_pipe_elastic;

    localparam int D = 5;

    logic        clk = 1'b0;
    logic        rstI = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] inData = '0;
    logic        outReady = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  flushStage = '0;

    logic        irC, ovC, irL, ovL;
    logic [31:0] odC, odL;
    logic [4:0]  svC, svL;
    logic [2:0]  ocC, ocL;

    seg_pipe_elastic #(.WIDTH(32), .DEPTH(D), .COLLAPSE(1'b1)) dutC (
        .clk_i(clk), .rst_i(rstI),
        .in_valid_i(inValid), .in_ready_o(irC), .in_data_i(inData),
        .out_valid_o(ovC), .out_ready_i(outReady), .out_data_o(odC),
        .flush_i(flush), .flush_stage_i(flushStage),
        .stage_valid_o(svC), .occ_o(ocC)
    );

    seg_pipe_elastic #(.WIDTH(32), .DEPTH(D), .COLLAPSE(1'b0)) dutL (
        .clk_i(clk), .rst_i(rstI),
        .in_valid_i(inValid), .in_ready_o(irL), .in_data_i(inData),
        .out_valid_o(ovL), .out_ready_i(outReady), .out_data_o(odL),
        .flush_i(flush), .flush_stage_i(flushStage),
        .stage_valid_o(svL), .occ_o(ocL)
    );

    always #5 clk = ~clk;

    // Model: in-flight items, oldest first, each with its stage number.
    int          cnt [2];
    int          pos [2][D];
    logic [31:0] dat [2][D];
    logic [31:0] expQ0[$];
    logic [31:0] expQ1[$];

    logic [4:0]  expSv  [2];
    int          expOcc [2];
    bit          expOv  [2];
    bit          expIr  [2];
    logic [31:0] expOd  [2];

    bit run = 1'b0;
    bit inRst = 1'b1;
    bit lastRst = 1'b1;
    bit postRst = 1'b0;
    int nChk = 0;
    int nFail = 0;

    task automatic cmp(input string n, input int m,
                       input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h",
                     n, m, $time, got, exp);
        end
    endtask

    task automatic modelEval(input int m);
        int          f, nc, removed, last, p;
        int          np [D];
        logic [31:0] nd [D];
        logic [31:0] tmp;
        bit          atExit, adv, st0Free, acc;
        f = (int'(flushStage) >= D) ? D - 1 : int'(flushStage);
        atExit    = (cnt[m] > 0) && (pos[m][0] == D - 1);
        expOv[m]  = atExit && !(flush && f == D - 1);
        expOd[m]  = dat[m][0];
        expOcc[m] = cnt[m];
        expSv[m]  = '0;
        for (int i = 0; i < cnt[m]; i++) expSv[m][pos[m][i]] = 1'b1;
        adv = outReady || !atExit;
        nc = 0;
        removed = 0;
        last = D;
        for (int i = 0; i < cnt[m]; i++) begin
            p = pos[m][i];
            if (flush && p <= f) begin
                removed++;
                continue;
            end
            if (m == 0) begin
                if (p == D - 1) begin
                    if (outReady) continue;
                    np[nc] = p;
                end else begin
                    np[nc] = (last == p + 1) ? p : p + 1;
                end
            end else begin
                if (!adv) np[nc] = p;
                else if (p == D - 1) continue;
                else np[nc] = p + 1;
            end
            nd[nc] = dat[m][i];
            last = np[nc];
            nc++;
        end
        st0Free  = (nc == 0) || (np[nc-1] != 0);
        expIr[m] = !flush && ((m == 0) ? st0Free : adv);
        acc      = inValid && expIr[m] && !inRst;
        if (inRst) begin
            cnt[m] = 0;
            if (m == 0) expQ0.delete();
            else expQ1.delete();
            return;
        end
        for (int i = 0; i < nc; i++) begin
            pos[m][i] = np[i];
            dat[m][i] = nd[i];
        end
        cnt[m] = nc;
        repeat (removed) begin
            if (m == 0 && expQ0.size() > 0) tmp = expQ0.pop_back();
            if (m == 1 && expQ1.size() > 0) tmp = expQ1.pop_back();
        end
        if (acc) begin
            pos[m][cnt[m]] = 0;
            dat[m][cnt[m]] = inData;
            cnt[m]++;
            if (m == 0) expQ0.push_back(inData);
            else expQ1.push_back(inData);
        end
    endtask

    task automatic drive(input bit iv, input logic [31:0] d, input bit ordy,
                         input bit fl, input logic [2:0] fs, input bit r);
        @(negedge clk);
        inValid    = iv && !r;
        inData     = d;
        outReady   = ordy && !r;
        flush      = fl && !r;
        flushStage = fs;
        rstI       = !r;
        inRst      = r;
        postRst    = lastRst;
        lastRst    = r;
        modelEval(0);
        modelEval(1);
        run = 1'b1;
    endtask

    task automatic chk(input int m, input logic ir, input logic ov,
                       input logic [31:0] od, input logic [4:0] sv,
                       input logic [2:0] oc);
        logic [31:0] e;
        cmp("stage_valid", m, 32'(sv), 32'(expSv[m]));
        cmp("occ", m, 32'(oc), 32'(expOcc[m]));
        cmp("out_valid", m, 32'(ov), 32'(expOv[m]));
        if (!inRst) cmp("in_ready", m, 32'(ir), 32'(expIr[m]));
        if (postRst) cmp("out_data_reset", m, od, 32'h0);
        if (ov && expOv[m]) cmp("out_data", m, od, expOd[m]);
        if (ov && outReady) begin
            if ((m == 0 && expQ0.size() == 0) ||
                (m == 1 && expQ1.size() == 0)) begin
                cmp("scoreboard_empty", m, od, 32'hDEAD_BEEF ^ od);
            end else begin
                e = (m == 0) ? expQ0.pop_front() : expQ1.pop_front();
                cmp("scoreboard", m, od, e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (run) begin
                chk(0, irC, ovC, odC, svC, ocC);
                chk(1, irL, ovL, odL, svL, ocL);
            end
        end
    end

    initial begin
        cnt[0] = 0;
        cnt[1] = 0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < D; i++) dat[m][i] = '0;
        repeat (2) drive(0, 0, 0, 0, 0, 1);
        // streaming
        for (int i = 0; i < 5; i++) drive(1, 32'h10 + i, 1, 0, 0, 0);
        repeat (6) drive(0, 0, 1, 0, 0, 0);
        // collapse vs lockstep under exit stall
        drive(1, 32'hA1, 1, 0, 0, 0);
        drive(1, 32'hA2, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 32'hA3 + i, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 1, 0, 0, 0);
        // partial flush, then full flush via out-of-range stage
        for (int i = 0; i < 5; i++) drive(1, 32'hB0 + i, 0, 0, 0, 0);
        drive(1, 32'hBF, 0, 1, 2, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 32'hC0 + i, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 0);
        drive(0, 0, 1, 0, 0, 0);
        // reset while full and stalled
        for (int i = 0; i < 5; i++) drive(1, 32'hD0 + i, 0, 0, 0, 0);
        drive(1, 32'hDF, 0, 0, 0, 1);
        drive(1, 32'h77, 1, 0, 0, 0);
        repeat (6) drive(0, 0, 1, 0, 0, 0);
        // full pipe with simultaneous in and out
        for (int i = 0; i < 5; i++) drive(1, 32'hE0 + i, 0, 0, 0, 0);
        drive(1, 32'h55, 1, 0, 0, 0);
        drive(1, 32'h56, 1, 0, 0, 0);
        repeat (8) drive(0, 0, 1, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0,
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 99) == 0);
        end
        repeat (10) drive(0, 0, 1, 0, 0, 0);
        #5;
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChk, nFail);
        $finish;
    end

endmodule
